nmos_ldr_chain: RTL and testbench

Parametrised two-phase load/shift register chain, the multi-bit, multi-stage successor of the single-bit NMOS load register. Each stage is a master/slave pair clocked by `main_clk` and qualified by PHI2/PHI1 enables. It adds parallel load, shift, recirculation, a rotation counter and phase-overlap detection. It sits in the NMOS functional library for dynamic shift registers, such as video/sprite shifters, and for pipeline latches.

---
 rtl/nmos_ldr_chain.sv | 144 ++++++++++++++
 tb/tb_nmos_ldr_chain.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nmos_ldr_chain.sv
// -----------------------------------------------------------------------------
// nmos_ldr_chain
//
// Multi-bit, multi-stage two-phase load/shift register chain. Each stage is a
// master/slave register pair clocked by main_clk. The C2 enable (PHI2) moves
// data into the masters, and the C1 enable (PHI1) moves masters into slaves.
// The chain supports parallel load into stage 0, shift, recirculation of the
// last stage back into stage 0, a shift-step counter modulo DEPTH with a wrap
// pulse, and a sticky flag for phase overlap (C1 and C2 at the same edge).
//
// Parameters
//   WIDTH    bits per stage (>= 1)
//   DEPTH    number of stages (>= 2)
//   RST_VAL  reset value of every master and slave register
//
// Ports
//   main_clk  in   system clock, all state changes on the rising edge
//   main_rst  in   synchronous active-high reset, overrides everything
//   C1        in   PHI1 enable: every slave takes its own master
//   C2        in   PHI2 enable: qualifies shift capture into the masters
//   LD        in   parallel load of D into the stage-0 master
//   D         in   load data, WIDTH bits
//   SH        in   shift enable, effective only together with C2
//   RC        in   recirculate: a shift feeds the last slave into stage 0
//   Q         out  last-stage slave
//   Q_ALL     out  all slaves, stage k at bits [k*WIDTH +: WIDTH]
//   CNT       out  shift-step count modulo DEPTH
//   WRAP      out  one-cycle pulse after CNT wraps DEPTH-1 -> 0
//   PERR      out  sticky phase-overlap error, cleared only by reset
// -----------------------------------------------------------------------------
module nmos_ldr_chain #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                                        main_clk,
    input  logic                                        main_rst,
    input  logic                                        C1,
    input  logic                                        C2,
    input  logic                                        LD,
    input  logic [WIDTH-1:0]                            D,
    input  logic                                        SH,
    input  logic                                        RC,
    output logic [WIDTH-1:0]                            Q,
    output logic [WIDTH*DEPTH-1:0]                      Q_ALL,
    output logic [((DEPTH > 2) ? $clog2(DEPTH) : 1)-1:0] CNT,
    output logic                                        WRAP,
    output logic                                        PERR
);

    localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    logic [WIDTH-1:0] r_master [DEPTH];
    logic [WIDTH-1:0] r_slave  [DEPTH];
    logic [WIDTH-1:0] w_master_nxt [DEPTH];
    logic [WIDTH-1:0] w_slave_nxt  [DEPTH];

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_wrap;
    logic          r_perr;

    logic w_shift;
    logic w_cnt_last;
    logic w_wrap_nxt;
    logic w_overlap;

    assign w_shift    = C2 & SH;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_overlap  = C1 & C2;

    // Next-state of the chain. Everything reads pre-edge register values only,
    // so a master updated at this edge is not seen by its slave until the next
    // C1 edge; under phase overlap both transfers simply use the old values.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_master_nxt[k] = r_master[k];
            w_slave_nxt[k]  = C1 ? r_master[k] : r_slave[k];
        end

        // Load beats recirculation; a plain shift leaves stage 0 holding.
        if (LD) begin
            w_master_nxt[0] = D;
        end else if (w_shift && RC) begin
            w_master_nxt[0] = r_slave[DEPTH-1];
        end

        for (int k = 1; k < DEPTH; k++) begin
            if (w_shift) begin
                w_master_nxt[k] = r_slave[k-1];
            end
        end
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (w_shift) begin
            if (w_cnt_last) begin
                w_cnt_nxt  = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_master[k] <= RST_VAL;
                r_slave[k]  <= RST_VAL;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_master[k] <= w_master_nxt[k];
                r_slave[k]  <= w_slave_nxt[k];
            end
        end
    end

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_wrap_nxt;
            r_perr <= r_perr | w_overlap;
        end
    end

    assign Q    = r_slave[DEPTH-1];
    assign CNT  = r_cnt;
    assign WRAP = r_wrap;
    assign PERR = r_perr;

    for (genvar g = 0; g < DEPTH; g++) begin : g_qall
        assign Q_ALL[g*WIDTH +: WIDTH] = r_slave[g];
    end

endmodule

// File: tb/tb_nmos_ldr_chain.sv
module tb_nmos_ldr_chain;

    logic        clk = 1'b0;
    logic        rst, c1, c2, ld, sh, rc;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [31:0] q_all;
    logic [1:0]  cnt;
    logic        wrap, perr;

    int checks = 0;
    int errors = 0;
    int wrap_seen;

    typedef struct {
        logic [31:0] q_all;
        logic [7:0]  q;
        logic [1:0]  cnt;
        logic        wrap;
        logic        perr;
    } exp_t;

    exp_t sb[$];

    // Reference model state (pre-edge values)
    logic [7:0] m_mst [4];
    logic [7:0] m_slv [4];
    logic [1:0] m_cnt;
    logic       m_wrap, m_perr;

    always #5 clk = ~clk;

    nmos_ldr_chain #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
        .main_clk(clk), .main_rst(rst), .C1(c1), .C2(c2), .LD(ld), .D(d),
        .SH(sh), .RC(rc), .Q(q), .Q_ALL(q_all), .CNT(cnt), .WRAP(wrap), .PERR(perr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic model_edge();
        logic [7:0] nm [4];
        logic [7:0] ns [4];
        logic       shf;
        exp_t       e;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_mst[k] = 8'h00;
                m_slv[k] = 8'h00;
            end
            m_cnt = 2'd0; m_wrap = 1'b0; m_perr = 1'b0;
        end else begin
            shf = c2 & sh;
            for (int k = 0; k < 4; k++) begin
                nm[k] = m_mst[k];
                ns[k] = c1 ? m_mst[k] : m_slv[k];
            end
            if (ld) nm[0] = d;
            else if (shf && rc) nm[0] = m_slv[3];
            for (int k = 1; k < 4; k++) if (shf) nm[k] = m_slv[k-1];
            m_wrap = shf && (m_cnt == 2'd3);
            if (shf) m_cnt = m_cnt + 2'd1;
            m_perr = m_perr | (c1 & c2);
            for (int k = 0; k < 4; k++) begin
                m_mst[k] = nm[k];
                m_slv[k] = ns[k];
            end
        end
        e.q_all = {m_slv[3], m_slv[2], m_slv[1], m_slv[0]};
        e.q     = m_slv[3];
        e.cnt   = m_cnt;
        e.wrap  = m_wrap;
        e.perr  = m_perr;
        sb.push_back(e);
    endtask

    // One clock: drive on the falling edge, push expectation, compare after the rising edge.
    task automatic step(input logic i_rst, i_c1, i_c2, i_ld, i_sh, i_rc, input logic [7:0] i_d);
        exp_t e;
        @(negedge clk);
        rst = i_rst; c1 = i_c1; c2 = i_c2; ld = i_ld; sh = i_sh; rc = i_rc; d = i_d;
        model_edge();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_q_all", q_all, e.q_all);
            chk("sb_q",     {24'd0, q}, {24'd0, e.q});
            chk("sb_cnt",   {30'd0, cnt}, {30'd0, e.cnt});
            chk("sb_wrap",  {31'd0, wrap}, {31'd0, e.wrap});
            chk("sb_perr",  {31'd0, perr}, {31'd0, e.perr});
        end
        if (wrap === 1'b1) wrap_seen++;
    endtask

    task automatic do_c1();
        step(0, 1, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic shift_step(input logic i_rc, input logic i_ld, input logic [7:0] i_d);
        step(0, 0, 1, i_ld, 1, i_rc, i_d);
        do_c1();
    endtask

    initial begin
        rst = 1; c1 = 0; c2 = 0; ld = 0; sh = 0; rc = 0; d = 8'h00;
        for (int k = 0; k < 4; k++) begin
            m_mst[k] = 8'hxx;
            m_slv[k] = 8'hxx;
        end
        m_cnt = 2'bxx; m_wrap = 1'bx; m_perr = 1'bx;

        // Reset with every other input active
        step(1, 1, 1, 1, 1, 1, 8'hFF);
        step(1, 1, 1, 1, 1, 1, 8'hFF);
        chk("rst_q", {24'd0, q}, 32'h0);
        chk("rst_q_all", q_all, 32'h0);
        chk("rst_cnt", {30'd0, cnt}, 32'h0);
        chk("rst_wrap", {31'd0, wrap}, 32'h0);
        chk("rst_perr", {31'd0, perr}, 32'h0);

        // Load then C1 transfer
        step(0, 0, 0, 1, 0, 0, 8'hA5);
        chk("ld_before_c1", {24'd0, q_all[7:0]}, 32'h0);
        do_c1();
        chk("ld_after_c1", {24'd0, q_all[7:0]}, 32'hA5);
        chk("ld_q", {24'd0, q}, 32'h0);

        // C2 without SH changes nothing
        step(0, 0, 1, 0, 0, 0, 8'h00);
        do_c1();
        chk("c2_nosh_cnt", {30'd0, cnt}, 32'h0);
        chk("c2_nosh_q_all", q_all, 32'h0000_00A5);

        // Shift to output
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 0, 8'h11);
        do_c1();
        wrap_seen = 0;
        for (int i = 0; i < 3; i++) shift_step(0, 0, 8'h00);
        chk("shift_q", {24'd0, q}, 32'h11);
        chk("shift_cnt", {30'd0, cnt}, 32'h3);
        chk("shift_nowrap", wrap_seen, 32'd0);

        // Recirculate: fill 0x04,0x03,0x02,0x01 using four shifting loads
        step(1, 0, 0, 0, 0, 0, 8'h00);
        shift_step(0, 1, 8'h01);
        shift_step(0, 1, 8'h02);
        shift_step(0, 1, 8'h03);
        shift_step(0, 1, 8'h04);
        chk("fill_q_all", q_all, 32'h0102_0304);
        chk("fill_cnt", {30'd0, cnt}, 32'h0);
        wrap_seen = 0;
        shift_step(1, 0, 8'h00);
        chk("rc_q1", {24'd0, q}, 32'h02);
        shift_step(1, 0, 8'h00);
        chk("rc_q2", {24'd0, q}, 32'h03);
        shift_step(1, 0, 8'h00);
        chk("rc_q3", {24'd0, q}, 32'h04);
        shift_step(1, 0, 8'h00);
        chk("rc_q4", {24'd0, q}, 32'h01);
        chk("rc_restored", q_all, 32'h0102_0304);
        chk("rc_wrap_once", wrap_seen, 32'd1);
        chk("rc_cnt", {30'd0, cnt}, 32'h0);

        // Priority: load wins over recirculation, other stages still shift
        shift_step(1, 1, 8'h5A);
        chk("prio_q_all", q_all, 32'h0203_045A);

        // Phase overlap
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 0, 8'h33);
        do_c1();
        step(0, 0, 0, 1, 0, 0, 8'h22);
        step(0, 1, 1, 0, 1, 0, 8'h00);
        chk("ovl_slave0", {24'd0, q_all[7:0]}, 32'h22);
        chk("ovl_perr", {31'd0, perr}, 32'h1);
        do_c1();
        chk("ovl_master1", {24'd0, q_all[15:8]}, 32'h33);
        shift_step(0, 0, 8'h00);
        shift_step(0, 0, 8'h00);
        chk("ovl_perr_sticky", {31'd0, perr}, 32'h1);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("ovl_perr_cleared", {31'd0, perr}, 32'h0);

        // Reset mid-shift clears everything at that edge
        step(0, 0, 0, 1, 0, 0, 8'h77);
        do_c1();
        step(1, 1, 1, 1, 1, 1, 8'hEE);
        chk("rst_mid_q_all", q_all, 32'h0);
        chk("rst_mid_cnt", {30'd0, cnt}, 32'h0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
